// File: rtl/instruction_fetch_unit_if.sv
// Purpose: bundles the instruction-memory bus, the decoder-side instruction
// handshake and the fetch control inputs of the instruction fetch unit.
// Ports (signals):
//   mem_req/mem_addr      fetch request and word address to instruction memory
//   mem_ack/mem_data      memory acknowledge and returned instruction word
//   instr/instr_valid     fetched instruction offered to the decoder
//   instr_ready           decoder accepts instr this cycle
//   jump_en/jump_addr     one-cycle redirect request and its target
//   halt                  level, blocks issuing new fetches
//   pc                    address of the next fetch
// Modports: master = fetch unit, slave = memory/decoder/control environment.
interface instruction_fetch_unit_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              instr_ready;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;
    logic              halt;
    logic [ADDR_W-1:0] pc;

    modport master (
        output mem_req, mem_addr, instr, instr_valid, pc,
        input  mem_ack, mem_data, instr_ready, jump_en, jump_addr, halt
    );

    modport slave (
        input  mem_req, mem_addr, instr, instr_valid, pc,
        output mem_ack, mem_data, instr_ready, jump_en, jump_addr, halt
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Purpose: instruction fetch unit. Holds the program counter, issues word
// fetches over a req/ack handshake, and hands each returned instruction to
// the decoder over a valid/ready handshake. Supports redirect and halt.
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous, active-high
//   bus    instruction_fetch_unit_if.master (memory bus, decoder handshake,
//          jump/halt control, pc)
// All outputs come straight from flops: mem_req/instr_valid are state
// decodes, mem_addr/pc are the pc register, instr is the capture register.
module instruction_fetch_unit #(
    parameter int              ADDR_W   = 4,
    parameter int              DATA_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic                       clk,
    input logic                       reset,
    instruction_fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              jpend_q, jpend_d;
    logic [ADDR_W-1:0] jtgt_q, jtgt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            jpend_q <= 1'b0;
            jtgt_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            jpend_q <= jpend_d;
            jtgt_q  <= jtgt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        jpend_d = jpend_q;
        jtgt_d  = jtgt_q;

        case (state_q)
            IDLE: begin
                if (bus.jump_en) begin
                    pc_d = bus.jump_addr;
                end
                if (!bus.halt) begin
                    state_d = REQ;
                end
            end

            REQ: begin
                if (bus.mem_ack) begin
                    if (bus.jump_en) begin
                        // Redirect arriving with the ack wins: the returned
                        // word belongs to the old stream and is dropped.
                        pc_d    = bus.jump_addr;
                        jpend_d = 1'b0;
                        state_d = bus.halt ? IDLE : REQ;
                    end else if (jpend_q) begin
                        pc_d    = jtgt_q;
                        jpend_d = 1'b0;
                        state_d = bus.halt ? IDLE : REQ;
                    end else begin
                        instr_d = bus.mem_data;
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = HOLD;
                    end
                end else if (bus.jump_en) begin
                    // The outstanding request must stay stable, so the
                    // target is parked until the memory answers.
                    jtgt_d  = bus.jump_addr;
                    jpend_d = 1'b1;
                end
            end

            HOLD: begin
                if (bus.jump_en) begin
                    // Flush: the held instruction is never consumed.
                    pc_d    = bus.jump_addr;
                    state_d = bus.halt ? IDLE : REQ;
                end else if (bus.instr_ready) begin
                    state_d = bus.halt ? IDLE : REQ;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_req     = (state_q == REQ);
    assign bus.instr_valid = (state_q == HOLD);
    assign bus.mem_addr    = pc_q;
    assign bus.pc          = pc_q;
    assign bus.instr       = instr_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic clk;
    logic reset;

    instruction_fetch_unit_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    instruction_fetch_unit #(.ADDR_W(4), .DATA_W(8), .RESET_PC(4'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Memory side: automatic zero-wait responder or manual directed drive.
    logic       mem_auto;
    logic       auto_ack;
    logic       man_ack;
    logic [7:0] man_data;

    assign bus.mem_ack  = mem_auto ? auto_ack : man_ack;
    assign bus.mem_data = mem_auto ? (8'hA0 | {4'h0, bus.mem_addr}) : man_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset) auto_ack = 1'b0;
        else       auto_ack = bus.mem_req && !auto_ack;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        auto_ack        = 1'b0;
        mem_auto        = 1'b1;
        man_ack         = 1'b0;
        man_data        = 8'h00;
        bus.instr_ready = 1'b1;
        bus.jump_en     = 1'b0;
        bus.jump_addr   = 4'h0;
        bus.halt        = 1'b0;
        reset           = 1'b1;
        tick;
        tick;
        chk("rst_req",   bus.mem_req, 0);
        chk("rst_valid", bus.instr_valid, 0);
        chk("rst_instr", bus.instr, 0);
        chk("rst_pc",    bus.pc, 0);
        chk("rst_addr",  bus.mem_addr, 0);
        reset = 1'b0;

        // Streaming fetch with zero-wait memory, pc wraps F -> 0.
        for (int i = 0; i < 17; i++) begin
            n = 0;
            while (!bus.instr_valid && n < 10) begin
                tick;
                n++;
            end
            chk("s_valid", bus.instr_valid, 1);
            chk("s_instr", bus.instr, 8'hA0 | (i % 16));
            chk("s_pc",    bus.pc, (i + 1) % 16);
            if (i > 0) chk("s_gap", n, 1);
            tick;
        end

        // Manual memory from a fresh reset.
        reset    = 1'b1;
        mem_auto = 1'b0;
        #1;
        reset = 1'b0;
        tick;
        chk("w_req0",  bus.mem_req, 1);
        chk("w_addr0", bus.mem_addr, 0);
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("w_req",   bus.mem_req, 1);
            chk("w_addr",  bus.mem_addr, 0);
            chk("w_valid", bus.instr_valid, 0);
        end
        man_ack = 1'b1; man_data = 8'h37;
        tick;
        man_ack = 1'b0;
        chk("w_valid1", bus.instr_valid, 1);
        chk("w_instr",  bus.instr, 8'h37);
        chk("w_req1",   bus.mem_req, 0);
        chk("w_pc",     bus.pc, 1);

        // Decoder backpressure.
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("bp_instr", bus.instr, 8'h37);
            chk("bp_valid", bus.instr_valid, 1);
            chk("bp_req",   bus.mem_req, 0);
        end
        bus.instr_ready = 1'b1;
        tick;
        chk("bp_valid0", bus.instr_valid, 0);
        chk("bp_req1",   bus.mem_req, 1);
        chk("bp_addr",   bus.mem_addr, 1);

        // Jump while holding an instruction (flush even with ready=1).
        bus.instr_ready = 1'b0;
        man_ack = 1'b1; man_data = 8'h55;
        tick;
        man_ack = 1'b0;
        chk("jh_instr", bus.instr, 8'h55);
        chk("jh_pc",    bus.pc, 2);
        bus.instr_ready = 1'b1;
        bus.jump_en = 1'b1; bus.jump_addr = 4'h9;
        tick;
        bus.jump_en = 1'b0;
        chk("jh_valid", bus.instr_valid, 0);
        chk("jh_req",   bus.mem_req, 1);
        chk("jh_addr",  bus.mem_addr, 4'h9);

        // Move to a fetch at A, then jump while that request is pending.
        bus.instr_ready = 1'b0;
        man_ack = 1'b1; man_data = 8'h66;
        tick;
        man_ack = 1'b0;
        chk("jp_instr0", bus.instr, 8'h66);
        bus.instr_ready = 1'b1;
        tick;
        chk("jp_addrA", bus.mem_addr, 4'hA);
        bus.jump_en = 1'b1; bus.jump_addr = 4'h9;
        tick;
        bus.jump_en = 1'b0;
        chk("jp_req",   bus.mem_req, 1);
        chk("jp_hold",  bus.mem_addr, 4'hA);
        tick;
        chk("jp_hold2", bus.mem_addr, 4'hA);
        man_ack = 1'b1; man_data = 8'hEE;
        tick;
        man_ack = 1'b0;
        chk("jp_valid", bus.instr_valid, 0);
        chk("jp_req2",  bus.mem_req, 1);
        chk("jp_addr9", bus.mem_addr, 4'h9);
        bus.instr_ready = 1'b0;
        man_ack = 1'b1; man_data = 8'h99;
        tick;
        man_ack = 1'b0;
        chk("jp_valid1", bus.instr_valid, 1);
        chk("jp_instr",  bus.instr, 8'h99);
        bus.instr_ready = 1'b1;
        tick;
        chk("jo_addrA", bus.mem_addr, 4'hA);

        // Second jump while pending overwrites the target.
        bus.jump_en = 1'b1; bus.jump_addr = 4'h3;
        tick;
        bus.jump_addr = 4'h5;
        tick;
        bus.jump_en = 1'b0;
        man_ack = 1'b1; man_data = 8'h11;
        tick;
        man_ack = 1'b0;
        chk("jo_valid", bus.instr_valid, 0);
        chk("jo_addr5", bus.mem_addr, 4'h5);

        // Jump coinciding with ack: data dropped, refetch from target.
        bus.jump_en = 1'b1; bus.jump_addr = 4'h7;
        man_ack = 1'b1; man_data = 8'h22;
        tick;
        bus.jump_en = 1'b0;
        man_ack = 1'b0;
        chk("ja_valid", bus.instr_valid, 0);
        chk("ja_req",   bus.mem_req, 1);
        chk("ja_addr7", bus.mem_addr, 4'h7);

        // Halt raised during a request.
        bus.halt = 1'b1;
        tick;
        chk("h_req", bus.mem_req, 1);
        bus.instr_ready = 1'b0;
        man_ack = 1'b1; man_data = 8'h77;
        tick;
        man_ack = 1'b0;
        chk("h_valid", bus.instr_valid, 1);
        chk("h_instr", bus.instr, 8'h77);
        bus.instr_ready = 1'b1;
        tick;
        chk("h_valid0", bus.instr_valid, 0);
        chk("h_idle",   bus.mem_req, 0);
        tick;
        chk("h_idle2", bus.mem_req, 0);
        bus.halt = 1'b0;
        tick;
        chk("h_req1", bus.mem_req, 1);
        chk("h_addr", bus.mem_addr, 4'h8);

        // Asynchronous reset mid-request, with a late ack.
        man_ack = 1'b1; man_data = 8'hBB;
        #2;
        reset = 1'b1;
        #1;
        chk("rq_req",   bus.mem_req, 0);
        chk("rq_pc",    bus.pc, 0);
        chk("rq_valid", bus.instr_valid, 0);
        tick;
        chk("rq_late", bus.instr_valid, 0);
        man_ack = 1'b0;
        reset = 1'b0;
        tick;
        chk("rq_req1", bus.mem_req, 1);
        chk("rq_addr", bus.mem_addr, 0);

        // Asynchronous reset while holding an instruction.
        bus.instr_ready = 1'b0;
        man_ack = 1'b1; man_data = 8'h42;
        tick;
        man_ack = 1'b0;
        chk("rh_instr0", bus.instr, 8'h42);
        #2;
        reset = 1'b1;
        #1;
        chk("rh_instr", bus.instr, 0);
        chk("rh_valid", bus.instr_valid, 0);
        chk("rh_pc",    bus.pc, 0);
        chk("rh_req",   bus.mem_req, 0);
        tick;
        reset = 1'b0;
        tick;
        chk("rh_req1", bus.mem_req, 1);
        chk("rh_addr", bus.mem_addr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
